// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC interrupt-acknowledge path.
package pic_pkg;

  localparam int unsigned LVL_W  = 3;
  localparam int unsigned NUM_IR = 8;

  typedef enum logic [1:0] {IDLE, PEND, ACK1, ACK2} state_e;

  typedef struct packed {
    logic             valid;
    logic [LVL_W-1:0] lvl;
  } lowest_t;

  // Index of the lowest set bit; IR0 is the highest priority.
  function automatic lowest_t lowest_set(input logic [NUM_IR-1:0] v);
    lowest_t r;
    r.valid = |v;
    r.lvl   = '0;
    for (int i = int'(NUM_IR) - 1; i >= 0; i--) begin
      if (v[i]) r.lvl = LVL_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Fully nested priority check: a request is eligible only if it outranks everything in service.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] req,
  input  logic [NUM_IR-1:0] isr,
  output logic [LVL_W-1:0]  req_lvl,
  output logic [LVL_W-1:0]  isr_lvl,
  output logic              eligible
);

  lowest_t req_low;
  lowest_t isr_low;

  always_comb begin
    req_low  = lowest_set(req);
    isr_low  = lowest_set(isr);
    req_lvl  = req_low.lvl;
    isr_lvl  = isr_low.lvl;
    eligible = req_low.valid && (!isr_low.valid || (req_low.lvl < isr_low.lvl));
  end

endmodule

// File: rtl/pic_inta_sequencer.sv
// 8086-mode INTA sequencer: raises INT, runs the two-pulse acknowledge, owns the ISR and EOI handling.
module pic_inta_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned SPURIOUS_LVL = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic [NUM_IR-1:0] irr,
  input  logic [NUM_IR-1:0] imr,
  input  logic [4:0]        icw2_base,
  input  logic              aeoi,
  input  logic              inta_n,
  input  logic              eoi_ns,
  input  logic              eoi_sp,
  input  logic [LVL_W-1:0]  eoi_level,
  output logic              int_out,
  output logic [NUM_IR-1:0] isr,
  output logic [NUM_IR-1:0] clr_irr,
  output logic [7:0]        vector,
  output logic              vector_oe
);

  state_e            state_q, state_d;
  logic              int_out_q, int_out_d;
  logic [NUM_IR-1:0] isr_q, isr_d;
  logic [NUM_IR-1:0] clr_irr_q, clr_irr_d;
  logic [7:0]        vector_q, vector_d;
  logic              vector_oe_q, vector_oe_d;
  logic              inta_q, inta_d;
  logic              spur_q, spur_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;

  logic [LVL_W-1:0]  req_lvl;
  logic [LVL_W-1:0]  isr_lvl;
  logic              eligible;
  logic              inta_fall;
  logic              inta_rise;
  logic [NUM_IR-1:0] isr_set;
  logic [NUM_IR-1:0] isr_clr;

  pic_priority_resolver u_resolver (
    .req      (irr & ~imr),
    .isr      (isr_q),
    .req_lvl  (req_lvl),
    .isr_lvl  (isr_lvl),
    .eligible (eligible)
  );

  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;

  always_comb begin
    state_d     = state_q;
    int_out_d   = int_out_q;
    clr_irr_d   = '0;
    vector_d    = vector_q;
    vector_oe_d = vector_oe_q;
    inta_d      = inta_n;
    spur_d      = spur_q;
    lvl_d       = lvl_q;
    isr_set     = '0;
    isr_clr     = '0;

    // EOI decodes against the pre-update ISR and is accepted in every state.
    if (eoi_ns && (isr_q != '0)) isr_clr[isr_lvl] = 1'b1;
    if (eoi_sp)                  isr_clr[eoi_level] = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (eligible) begin
          int_out_d = 1'b1;
          state_d   = PEND;
        end
      end
      PEND: begin
        if (inta_fall) begin
          int_out_d = 1'b0;
          state_d   = ACK1;
          if (eligible) begin
            lvl_d              = req_lvl;
            spur_d             = 1'b0;
            isr_set[req_lvl]   = 1'b1;
            clr_irr_d[req_lvl] = 1'b1;
          end else begin
            lvl_d  = LVL_W'(SPURIOUS_LVL);
            spur_d = 1'b1;
          end
        end
      end
      ACK1: begin
        if (inta_fall) begin
          vector_d    = {icw2_base, lvl_q};
          vector_oe_d = 1'b1;
          state_d     = ACK2;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          vector_oe_d = 1'b0;
          if (aeoi && !spur_q) isr_clr[lvl_q] = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear before set so an acknowledge wins over a coincident EOI.
    isr_d = (isr_q & ~isr_clr) | isr_set;

    if (init) begin
      state_d     = IDLE;
      int_out_d   = 1'b0;
      isr_d       = '0;
      clr_irr_d   = '0;
      vector_d    = '0;
      vector_oe_d = 1'b0;
      inta_d      = 1'b1;
      spur_d      = 1'b0;
      lvl_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      int_out_q   <= 1'b0;
      isr_q       <= '0;
      clr_irr_q   <= '0;
      vector_q    <= '0;
      vector_oe_q <= 1'b0;
      inta_q      <= 1'b1;
      spur_q      <= 1'b0;
      lvl_q       <= '0;
    end else begin
      state_q     <= state_d;
      int_out_q   <= int_out_d;
      isr_q       <= isr_d;
      clr_irr_q   <= clr_irr_d;
      vector_q    <= vector_d;
      vector_oe_q <= vector_oe_d;
      inta_q      <= inta_d;
      spur_q      <= spur_d;
      lvl_q       <= lvl_d;
    end
  end

  assign int_out   = int_out_q;
  assign isr       = isr_q;
  assign clr_irr   = clr_irr_q;
  assign vector    = vector_q;
  assign vector_oe = vector_oe_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench for pic_inta_sequencer with a queue-based scoreboard for vectors and IRR clears.
module tb_pic_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       init;
  logic [7:0] irr;
  logic [7:0] imr;
  logic [4:0] icw2_base;
  logic       aeoi;
  logic       inta_n;
  logic       eoi_ns;
  logic       eoi_sp;
  logic [2:0] eoi_level;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] clr_irr;
  logic [7:0] vector;
  logic       vector_oe;

  int checks = 0;
  int errors = 0;

  logic [7:0] vec_q[$];
  logic [7:0] clr_q[$];

  pic_inta_sequencer #(.SPURIOUS_LVL(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .init      (init),
    .irr       (irr),
    .imr       (imr),
    .icw2_base (icw2_base),
    .aeoi      (aeoi),
    .inta_n    (inta_n),
    .eoi_ns    (eoi_ns),
    .eoi_sp    (eoi_sp),
    .eoi_level (eoi_level),
    .int_out   (int_out),
    .isr       (isr),
    .clr_irr   (clr_irr),
    .vector    (vector),
    .vector_oe (vector_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT drives a vector or pulses clr_irr.
  logic       prev_oe  = 1'b0;
  logic [7:0] prev_clr = 8'h00;
  always @(negedge clk) begin
    if (vector_oe && !prev_oe) begin
      if (vec_q.size() == 0) chk("unexpected_vector", vector, 8'hxx);
      else chk("vector", vector, vec_q.pop_front());
    end
    if (prev_clr != 8'h00) chk("clr_irr_one_cycle", clr_irr, 8'h00);
    else if (clr_irr != 8'h00) begin
      if (clr_q.size() == 0) chk("unexpected_clr_irr", clr_irr, 8'h00);
      else chk("clr_irr", clr_irr, clr_q.pop_front());
    end
    prev_oe  = vector_oe;
    prev_clr = clr_irr;
  end

  task automatic ack(input logic [7:0] ev, input logic [7:0] ec,
                     input logic [7:0] ei1, input logic [7:0] eif);
    vec_q.push_back(ev);
    if (ec != 8'h00) clr_q.push_back(ec);
    inta_n = 1'b0;
    tick();
    chk("isr_after_inta1", isr, ei1);
    chk("int_low_in_ack1", {7'd0, int_out}, 8'h00);
    irr = irr & ~ec;
    inta_n = 1'b1;
    tick();
    tick();
    chk("oe_low_between", {7'd0, vector_oe}, 8'h00);
    inta_n = 1'b0;
    tick();
    chk("oe_on", {7'd0, vector_oe}, 8'h01);
    tick();
    chk("oe_held", {7'd0, vector_oe}, 8'h01);
    inta_n = 1'b1;
    tick();
    chk("oe_off", {7'd0, vector_oe}, 8'h00);
    chk("isr_after_ack", isr, eif);
    tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_int"}, {7'd0, int_out}, 8'h00);
    chk({tag, "_isr"}, isr, 8'h00);
    chk({tag, "_clr"}, clr_irr, 8'h00);
    chk({tag, "_vec"}, vector, 8'h00);
    chk({tag, "_oe"}, {7'd0, vector_oe}, 8'h00);
  endtask

  task automatic pulse_eoi(input logic ns, input logic sp, input logic [2:0] lvl);
    eoi_ns = ns; eoi_sp = sp; eoi_level = lvl;
    tick();
    eoi_ns = 1'b0; eoi_sp = 1'b0;
  endtask

  initial begin
    rst = 1'b0; init = 1'b0; irr = 8'h00; imr = 8'h00; icw2_base = 5'b11111;
    aeoi = 1'b0; inta_n = 1'b1; eoi_ns = 1'b0; eoi_sp = 1'b0; eoi_level = 3'd0;
    tick(); tick();
    chk_reset("por");
    rst = 1'b1;
    tick();

    // Single request on IR6
    irr = 8'h40;
    tick();
    chk("single_int", {7'd0, int_out}, 8'h01);
    ack(8'hFE, 8'h40, 8'h40, 8'h40);

    // Nesting: IR5 preempts IR6 in service
    irr = 8'h60;
    tick();
    chk("nest_int", {7'd0, int_out}, 8'h01);
    ack(8'hFD, 8'h20, 8'h60, 8'h60);
    chk("nest_int_blocked", {7'd0, int_out}, 8'h00);
    pulse_eoi(1'b1, 1'b0, 3'd0);
    chk("nest_eoi_ns", isr, 8'h40);
    irr = 8'h00;
    pulse_eoi(1'b1, 1'b0, 3'd0);
    chk("nest_eoi_ns2", isr, 8'h00);

    // Blocked request until specific EOI frees IR2
    irr = 8'h04;
    tick();
    ack(8'hFA, 8'h04, 8'h04, 8'h04);
    irr = 8'h10;
    tick(); tick();
    chk("blocked_int", {7'd0, int_out}, 8'h00);
    pulse_eoi(1'b0, 1'b1, 3'd2);
    chk("blocked_eoi_sp", isr, 8'h00);
    tick();
    chk("unblocked_int", {7'd0, int_out}, 8'h01);
    ack(8'hFC, 8'h10, 8'h10, 8'h10);
    pulse_eoi(1'b1, 1'b0, 3'd0);
    chk("blocked_cleanup", isr, 8'h00);

    // Spurious: request withdrawn while pending
    icw2_base = 5'b10000;
    irr = 8'h08;
    tick();
    chk("spur_int", {7'd0, int_out}, 8'h01);
    irr = 8'h00;
    tick();
    chk("spur_int_held", {7'd0, int_out}, 8'h01);
    ack(8'h87, 8'h00, 8'h00, 8'h00);

    // AEOI on IR0, then a masked request
    icw2_base = 5'b11111;
    aeoi = 1'b1;
    irr = 8'h01;
    tick();
    ack(8'hF8, 8'h01, 8'h01, 8'h00);
    aeoi = 1'b0;
    imr = 8'h01;
    irr = 8'h01;
    tick(); tick();
    chk("masked_int", {7'd0, int_out}, 8'h00);
    imr = 8'h00;
    irr = 8'h00;
    tick();

    // Async reset while in ACK1
    irr = 8'h02;
    tick();
    clr_q.push_back(8'h02);
    inta_n = 1'b0;
    tick();
    chk("mid_isr", isr, 8'h02);
    irr = 8'h00;
    inta_n = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk_reset("mid_rst");
    tick();
    rst = 1'b1;
    tick();

    // Synchronous init while in ACK1
    irr = 8'h02;
    tick();
    clr_q.push_back(8'h02);
    inta_n = 1'b0;
    tick();
    irr = 8'h00;
    inta_n = 1'b1;
    tick();
    init = 1'b1;
    tick();
    init = 1'b0;
    chk_reset("mid_init");

    // INTA in IDLE is ignored, then a normal acknowledge completes
    inta_n = 1'b0;
    tick(); tick();
    inta_n = 1'b1;
    tick();
    chk("idle_inta_oe", {7'd0, vector_oe}, 8'h00);
    irr = 8'h08;
    tick();
    chk("post_int", {7'd0, int_out}, 8'h01);
    ack(8'hFB, 8'h08, 8'h08, 8'h08);

    tick(); tick();
    chk("vec_queue_empty", 8'(vec_q.size()), 8'h00);
    chk("clr_queue_empty", 8'(clr_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
